alu_decode_stage: RTL and testbench

- ID→EX pipeline stage that turns a 32-bit RV32I instruction into the 5-bit ALU operation code and the control and immediate fields the ALU datapath consumes.
- Acts as the producer side of the ALU op/operand interface.
- Upstream and downstream links use valid/ready handshakes.
- A 2-entry skid buffer registers all outputs, so backpressure never creates a combinational ready path.

---
 rtl/alu_decode_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// ID->EX stage: decodes an RV32I instruction into ALU op, immediate and control bits,
// registered through a 2-entry skid buffer. Optional macro ALU_DEC_ILLEGAL_EN flags illegal encodings.
module alu_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] iv_instr,
   input  logic [XLEN-1:0] iv_pc,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [4:0]      ov_ALUop,
   output logic [XLEN-1:0] ov_imm,
   output logic [XLEN-1:0] ov_pc,
   output logic [4:0]      ov_rs1,
   output logic [4:0]      ov_rs2,
   output logic [4:0]      ov_rd,
   output logic            o_srcA_pc,
   output logic            o_srcB_imm,
   output logic            o_reg_write,
   output logic            o_mem_read,
   output logic            o_mem_write,
   output logic            o_branch,
   output logic            o_jump,
   output logic            o_br_on_zero,
   output logic            o_illegal
);

   typedef struct packed {
      logic [4:0]      alu_op;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            src_a_pc;
      logic            src_b_imm;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            br_on_zero;
      logic            illegal;
   } bundle_t;

   localparam logic [4:0] ALU_ADD  = 5'b00000, ALU_SUB  = 5'b00010, ALU_SLL  = 5'b00100;
   localparam logic [4:0] ALU_SLT  = 5'b01000, ALU_SLTU = 5'b01100, ALU_XOR  = 5'b10000;
   localparam logic [4:0] ALU_SRL  = 5'b10100, ALU_SRA  = 5'b10110, ALU_OR   = 5'b11000;
   localparam logic [4:0] ALU_AND  = 5'b11100, ALU_BGE  = 5'b11010, ALU_BGEU = 5'b11110;
   localparam logic [4:0] ALU_PASSB = 5'b11101;

   // funct3 -> ALU op for R/I arithmetic; alt selects sub/sra
   function automatic logic [4:0] op_map(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  op_map = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op_map = ALU_SLL;
         3'b010:  op_map = ALU_SLT;
         3'b011:  op_map = ALU_SLTU;
         3'b100:  op_map = ALU_XOR;
         3'b101:  op_map = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op_map = ALU_OR;
         default: op_map = ALU_AND;
      endcase
   endfunction

   logic [6:0]      opcode, f7;
   logic [2:0]      f3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   logic            bad;
   bundle_t         dec;

   assign opcode = iv_instr[6:0];
   assign f3     = iv_instr[14:12];
   assign f7     = iv_instr[31:25];
   assign imm_i  = {{20{iv_instr[31]}}, iv_instr[31:20]};
   assign imm_s  = {{20{iv_instr[31]}}, iv_instr[31:25], iv_instr[11:7]};
   assign imm_b  = {{19{iv_instr[31]}}, iv_instr[31], iv_instr[7], iv_instr[30:25], iv_instr[11:8], 1'b0};
   assign imm_u  = {iv_instr[31:12], 12'b0};
   assign imm_j  = {{11{iv_instr[31]}}, iv_instr[31], iv_instr[19:12], iv_instr[20], iv_instr[30:21], 1'b0};
   assign imm_sh = {27'b0, iv_instr[24:20]};

   always_comb begin
      dec     = '0;
      bad     = 1'b0;
      dec.pc  = iv_pc;
      dec.rs1 = iv_instr[19:15];
      dec.rs2 = iv_instr[24:20];
      dec.rd  = iv_instr[11:7];
      case (opcode)
         7'b0110011: begin
            dec.alu_op    = op_map(f3, f7[5]);
            dec.reg_write = 1'b1;
            bad = !((f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         7'b0010011: begin
            dec.reg_write = 1'b1;
            dec.src_b_imm = 1'b1;
            dec.imm       = imm_i;
            if (f3 == 3'b001) begin
               dec.alu_op = ALU_SLL;
               dec.imm    = imm_sh;
               bad        = (f7 != 7'b0000000);
            end else if (f3 == 3'b101) begin
               dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
               dec.imm    = imm_sh;
               bad        = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
            end else begin
               dec.alu_op = op_map(f3, 1'b0);
            end
         end
         7'b0000011: begin
            dec.imm       = imm_i;
            dec.src_b_imm = 1'b1;
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
         end
         7'b0100011: begin
            dec.imm       = imm_s;
            dec.src_b_imm = 1'b1;
            dec.mem_write = 1'b1;
         end
         7'b1100011: begin
            dec.branch = 1'b1;
            dec.imm    = imm_b;
            case (f3)
               3'b000: begin dec.alu_op = ALU_SUB; dec.br_on_zero = 1'b1; end
               3'b001:  dec.alu_op = ALU_SUB;
               3'b100:  dec.alu_op = ALU_SLT;
               3'b101:  dec.alu_op = ALU_BGE;
               3'b110:  dec.alu_op = ALU_SLTU;
               3'b111:  dec.alu_op = ALU_BGEU;
               default: bad = 1'b1;
            endcase
         end
         7'b0110111: begin
            dec.alu_op    = ALU_PASSB;
            dec.imm       = imm_u;
            dec.reg_write = 1'b1;
         end
         7'b0010111: begin
            dec.imm       = imm_u;
            dec.src_a_pc  = 1'b1;
            dec.src_b_imm = 1'b1;
            dec.reg_write = 1'b1;
         end
         7'b1101111: begin
            dec.imm       = imm_j;
            dec.src_a_pc  = 1'b1;
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
         end
         7'b1100111: begin
            dec.imm       = imm_i;
            dec.src_b_imm = 1'b1;
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
            bad           = (f3 != 3'b000);
         end
         default: bad = 1'b1;
      endcase
      // Illegal encodings become a side-effect-free add; only the flag differs by build
      if (bad) begin
         dec.alu_op     = ALU_ADD;
         dec.src_a_pc   = 1'b0;
         dec.src_b_imm  = 1'b0;
         dec.reg_write  = 1'b0;
         dec.mem_read   = 1'b0;
         dec.mem_write  = 1'b0;
         dec.branch     = 1'b0;
         dec.jump       = 1'b0;
         dec.br_on_zero = 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
         dec.illegal    = 1'b1;
`else
         dec.illegal    = 1'b0;
`endif
      end
   end

   // Handshake: a transfer happens on a cycle where both valid and ready are high.
   bundle_t main_q, main_d, skid_q, skid_d;
   logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic    accept, take;

   assign o_ready = !skid_valid_q;
   assign o_valid = main_valid_q;
   assign accept  = i_valid && o_ready;
   assign take    = main_valid_q && i_ready;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (i_flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (take) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d = dec;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q) begin
            main_d       = dec;
            main_valid_d = 1'b1;
         end else begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign ov_ALUop     = main_q.alu_op;
   assign ov_imm       = main_q.imm;
   assign ov_pc        = main_q.pc;
   assign ov_rs1       = main_q.rs1;
   assign ov_rs2       = main_q.rs2;
   assign ov_rd        = main_q.rd;
   assign o_srcA_pc    = main_q.src_a_pc;
   assign o_srcB_imm   = main_q.src_b_imm;
   assign o_reg_write  = main_q.reg_write;
   assign o_mem_read   = main_q.mem_read;
   assign o_mem_write  = main_q.mem_write;
   assign o_branch     = main_q.branch;
   assign o_jump       = main_q.jump;
   assign o_br_on_zero = main_q.br_on_zero;
   assign o_illegal    = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed decode table plus stall, flush and reset sequences.
module tb_alu_decode_stage;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_valid, i_flush, i_ready;
   logic        o_ready, o_valid;
   logic [31:0] iv_instr, iv_pc, ov_imm, ov_pc;
   logic [4:0]  ov_ALUop, ov_rs1, ov_rs2, ov_rd;
   logic        o_srcA_pc, o_srcB_imm, o_reg_write, o_mem_read, o_mem_write;
   logic        o_branch, o_jump, o_br_on_zero, o_illegal;

   int n_vec = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   alu_decode_stage dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .iv_instr(iv_instr), .iv_pc(iv_pc), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .ov_ALUop(ov_ALUop), .ov_imm(ov_imm), .ov_pc(ov_pc),
      .ov_rs1(ov_rs1), .ov_rs2(ov_rs2), .ov_rd(ov_rd), .o_srcA_pc(o_srcA_pc),
      .o_srcB_imm(o_srcB_imm), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
      .o_mem_write(o_mem_write), .o_branch(o_branch), .o_jump(o_jump),
      .o_br_on_zero(o_br_on_zero), .o_illegal(o_illegal)
   );

   // control vector layout: {srcA_pc, srcB_imm, reg_write, mem_read, mem_write, branch, jump, br_on_zero}
   localparam logic [7:0] C_A = 8'h80, C_B = 8'h40, C_RW = 8'h20, C_MR = 8'h10;
   localparam logic [7:0] C_MW = 8'h08, C_BR = 8'h04, C_J = 8'h02, C_Z = 8'h01;

`ifdef ALU_DEC_ILLEGAL_EN
   localparam logic EXP_ILL = 1'b1;
`else
   localparam logic EXP_ILL = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  alu;
      logic [31:0] imm;
      logic        chk_imm;
      logic [7:0]  ctrl;
      logic        ill;
      logic [4:0]  rs1, rs2, rd;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [7:0] ctrl_now();
      return {o_srcA_pc, o_srcB_imm, o_reg_write, o_mem_read, o_mem_write,
              o_branch, o_jump, o_br_on_zero};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_bundle(input string tag, input vec_t v, input logic [31:0] pc);
      chk({tag, " valid"}, {31'b0, o_valid}, 32'd1);
      chk({tag, " aluop"}, {27'b0, ov_ALUop}, {27'b0, v.alu});
      chk({tag, " ctrl"}, {24'b0, ctrl_now()}, {24'b0, v.ctrl});
      chk({tag, " illegal"}, {31'b0, o_illegal}, {31'b0, v.ill});
      chk({tag, " regs"}, {17'b0, ov_rs1, ov_rs2, ov_rd}, {17'b0, v.rs1, v.rs2, v.rd});
      chk({tag, " pc"}, ov_pc, pc);
      if (v.chk_imm) chk({tag, " imm"}, ov_imm, v.imm);
   endtask

   task automatic check_zero_payload(input string tag);
      chk({tag, " aluop"}, {27'b0, ov_ALUop}, 32'd0);
      chk({tag, " ctrl"}, {24'b0, ctrl_now()}, 32'd0);
      chk({tag, " illegal"}, {31'b0, o_illegal}, 32'd0);
      chk({tag, " imm"}, ov_imm, 32'd0);
      chk({tag, " pc"}, ov_pc, 32'd0);
      chk({tag, " regs"}, {17'b0, ov_rs1, ov_rs2, ov_rd}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{32'h002081B3, 5'b00000, 32'h0, 1'b0, C_RW, 1'b0, 5'd1, 5'd2, 5'd3};          // add
      vecs[1]  = '{32'h407302B3, 5'b00010, 32'h0, 1'b0, C_RW, 1'b0, 5'd6, 5'd7, 5'd5};          // sub
      vecs[2]  = '{32'h40315093, 5'b10110, 32'h3, 1'b1, C_B | C_RW, 1'b0, 5'd2, 5'd3, 5'd1};    // srai
      vecs[3]  = '{32'h12345537, 5'b11101, 32'h12345000, 1'b1, C_RW, 1'b0, 5'd8, 5'd3, 5'd10};  // lui
      vecs[4]  = '{32'h0020D463, 5'b11010, 32'h8, 1'b1, C_BR, 1'b0, 5'd1, 5'd2, 5'd8};          // bge
      vecs[5]  = '{32'hFFF00093, 5'b00000, 32'hFFFFFFFF, 1'b1, C_B | C_RW, 1'b0, 5'd0, 5'd31, 5'd1}; // addi -1
      vecs[6]  = '{32'h00412283, 5'b00000, 32'h4, 1'b1, C_B | C_MR | C_RW, 1'b0, 5'd2, 5'd4, 5'd5}; // lw
      vecs[7]  = '{32'h00512423, 5'b00000, 32'h8, 1'b1, C_B | C_MW, 1'b0, 5'd2, 5'd5, 5'd8};     // sw
      vecs[8]  = '{32'hFE208EE3, 5'b00010, 32'hFFFFFFFC, 1'b1, C_BR | C_Z, 1'b0, 5'd1, 5'd2, 5'd29}; // beq -4
      vecs[9]  = '{32'h010000EF, 5'b00000, 32'h10, 1'b1, C_A | C_J | C_RW, 1'b0, 5'd0, 5'd16, 5'd1}; // jal
      vecs[10] = '{32'h00001117, 5'b00000, 32'h1000, 1'b1, C_A | C_B | C_RW, 1'b0, 5'd0, 5'd0, 5'd2}; // auipc
      vecs[11] = '{32'h0062B233, 5'b01100, 32'h0, 1'b0, C_RW, 1'b0, 5'd5, 5'd6, 5'd4};          // sltu
      vecs[12] = '{32'hFFFFFFFF, 5'b00000, 32'h0, 1'b0, 8'h00, EXP_ILL, 5'd31, 5'd31, 5'd31};  // bad opcode
      vecs[13] = '{32'h40311093, 5'b00000, 32'h0, 1'b0, 8'h00, EXP_ILL, 5'd2, 5'd3, 5'd1};     // slli bad funct7

      i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      iv_instr = 32'h0; iv_pc = 32'h0;
      step(); step();
      chk("reset valid", {31'b0, o_valid}, 32'd0);
      chk("reset ready", {31'b0, o_ready}, 32'd1);
      check_zero_payload("reset");
      i_rst_n = 1'b1;
      step();

      // back-to-back table: each bundle appears the cycle after it is accepted
      for (int i = 0; i < 14; i++) begin
         i_valid  = 1'b1;
         iv_instr = vecs[i].instr;
         iv_pc    = 32'h1000 + 32'(i) * 4;
         step();
         check_bundle($sformatf("vec%0d", i), vecs[i], 32'h1000 + 32'(i) * 4);
      end
      i_valid = 1'b0;
      step();
      chk("drain valid", {31'b0, o_valid}, 32'd0);

      // stall: A into main, B into skid, C held upstream
      i_ready = 1'b0; i_valid = 1'b1; iv_instr = vecs[0].instr; iv_pc = 32'hA0;
      step();
      check_bundle("stall A", vecs[0], 32'hA0);
      chk("stall ready1", {31'b0, o_ready}, 32'd1);
      iv_instr = vecs[1].instr; iv_pc = 32'hB0;
      step();
      chk("stall ready2", {31'b0, o_ready}, 32'd0);
      check_bundle("stall hold A", vecs[0], 32'hA0);
      iv_instr = vecs[11].instr; iv_pc = 32'hC0;
      step();
      chk("stall ready3", {31'b0, o_ready}, 32'd0);
      check_bundle("stall hold A2", vecs[0], 32'hA0);
      step();
      check_bundle("stall hold A3", vecs[0], 32'hA0);
      i_ready = 1'b1;
      step();
      check_bundle("drain B", vecs[1], 32'hB0);
      chk("drain ready", {31'b0, o_ready}, 32'd1);
      step();
      check_bundle("drain C", vecs[11], 32'hC0);
      i_valid = 1'b0;
      step();
      chk("drain empty", {31'b0, o_valid}, 32'd0);

      // flush with stage full and an incoming instruction
      i_ready = 1'b0; i_valid = 1'b1; iv_instr = vecs[0].instr; iv_pc = 32'hD0;
      step();
      iv_pc = 32'hD4;
      step();
      chk("full ready", {31'b0, o_ready}, 32'd0);
      i_flush = 1'b1; iv_pc = 32'hD8;
      step();
      chk("flush valid", {31'b0, o_valid}, 32'd0);
      chk("flush ready", {31'b0, o_ready}, 32'd1);
      i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      step();
      chk("post flush valid", {31'b0, o_valid}, 32'd0);

      // reset mid-stall with an incoming instruction
      i_ready = 1'b0; i_valid = 1'b1; iv_instr = vecs[6].instr; iv_pc = 32'hE0;
      step();
      iv_pc = 32'hE4;
      step();
      i_rst_n = 1'b0; iv_pc = 32'hE8;
      step();
      chk("rst valid", {31'b0, o_valid}, 32'd0);
      chk("rst ready", {31'b0, o_ready}, 32'd1);
      check_zero_payload("rst");
      i_rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
      step();
      chk("post rst valid", {31'b0, o_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
